pendulum_result_streamer: RTL

Downstream stage of the Pendulum Compute array. It captures one batch of PE_NUM results (next state, observation, reward, done) when Compute pulses o_valid. It holds the next-state bus for feedback into the next step. It serializes the observations, rewards and done flags as 32-bit words over a valid/ready stream to the host interface. o_busy blocks the controller from re-enabling Compute while a batch is still draining.

---
 rtl/pendulum_result_streamer.sv | 134 +++++++++++++
 1 files changed

// File: rtl/pendulum_result_streamer.sv
// pendulum_result_streamer: captures one Compute batch and streams obs/rwd/done as 32-bit words.
// Define STA_OUT_EN to append each PE's state (th, th_dot) to its record.
module pendulum_result_streamer #(
    parameter int PE_NUM = 40,
    parameter int STA_WL = 64,
    parameter int OBS_WL = 96,
    parameter int RWD_WL = 32
) (
    input  logic                     i_clk,
    input  logic                     i_rstn,
    input  logic                     i_valid,
    input  logic [PE_NUM*STA_WL-1:0] i_sta,
    input  logic [PE_NUM*OBS_WL-1:0] i_obs,
    input  logic [PE_NUM*RWD_WL-1:0] i_rwd,
    input  logic [PE_NUM-1:0]        i_done,
    output logic                     o_busy,
    output logic [PE_NUM*STA_WL-1:0] o_sta,
    output logic [31:0]              o_data,
    output logic                     o_dvalid,
    input  logic                     i_dready,
    output logic                     o_last,
    output logic                     o_overflow,
    output logic [15:0]              o_batch_cnt
);
`ifdef STA_OUT_EN
    localparam int REC_WORDS = 6;
`else
    localparam int REC_WORDS = 4;
`endif
    localparam int DONE_WORDS = (PE_NUM + 31) / 32;
    localparam int DP = DONE_WORDS * 32;
    localparam int IW = $clog2(PE_NUM);
    localparam int SW = $clog2(REC_WORDS);

    typedef enum logic [1:0] {IDLE, STREAM, MASK} state_t;

    state_t                   state_q, state_d;
    logic [IW-1:0]            rec_q, rec_d;
    logic [SW-1:0]            sub_q, sub_d;
    logic [PE_NUM*OBS_WL-1:0] obs_q, obs_d;
    logic [PE_NUM*RWD_WL-1:0] rwd_q, rwd_d;
    logic [PE_NUM*STA_WL-1:0] sta_q, sta_d;
    logic [PE_NUM-1:0]        done_q, done_d;
    logic                     ovf_q, ovf_d;
    logic [15:0]              cnt_q, cnt_d;
    logic [31:0]              words [PE_NUM][REC_WORDS];
    logic [DP-1:0]            done_pad;
    logic [31:0]              mask_word;
    logic                     xfer, rec_end, sub_end;

    for (genvar g = 0; g < PE_NUM; g++) begin : g_rec
        assign words[g][0] = obs_q[g*OBS_WL +: 32];
        assign words[g][1] = obs_q[g*OBS_WL+32 +: 32];
        assign words[g][2] = obs_q[g*OBS_WL+64 +: 32];
        assign words[g][3] = rwd_q[g*RWD_WL +: 32];
`ifdef STA_OUT_EN
        assign words[g][4] = sta_q[g*STA_WL +: 32];
        assign words[g][5] = sta_q[g*STA_WL+32 +: 32];
`endif
    end

    // done bits beyond PE_NUM read as zero in the last mask word
    assign done_pad = DP'(done_q);

    always_comb begin
        mask_word = '0;
        for (int j = 0; j < DONE_WORDS; j++)
            if (rec_q == IW'(j)) mask_word = done_pad[j*32 +: 32];
    end

    assign o_busy      = state_q != IDLE;
    assign o_dvalid    = o_busy;
    assign o_last      = state_q == MASK && rec_q == IW'(DONE_WORDS-1);
    assign o_data      = state_q == STREAM ? words[rec_q][sub_q] : state_q == MASK ? mask_word : '0;
    assign o_sta       = sta_q;
    assign o_overflow  = ovf_q;
    assign o_batch_cnt = cnt_q;
    assign xfer        = o_dvalid && i_dready;
    assign sub_end     = sub_q == SW'(REC_WORDS-1);
    assign rec_end     = rec_q == IW'(PE_NUM-1);

    always_comb begin
        state_d = state_q;
        rec_d   = rec_q;
        sub_d   = sub_q;
        obs_d   = obs_q;
        rwd_d   = rwd_q;
        sta_d   = sta_q;
        done_d  = done_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q | (i_valid && state_q != IDLE);
        if (state_q == IDLE && i_valid) begin
            obs_d   = i_obs;
            rwd_d   = i_rwd;
            sta_d   = i_sta;
            done_d  = i_done;
            rec_d   = '0;
            sub_d   = '0;
            state_d = STREAM;
        end else if (state_q == STREAM && xfer) begin
            sub_d   = sub_end ? '0 : sub_q + 1'b1;
            rec_d   = !sub_end ? rec_q : rec_end ? '0 : rec_q + 1'b1;
            state_d = sub_end && rec_end ? MASK : STREAM;
        end else if (state_q == MASK && xfer) begin
            rec_d   = o_last ? '0 : rec_q + 1'b1;
            state_d = o_last ? IDLE : MASK;
            cnt_d   = o_last ? cnt_q + 16'd1 : cnt_q;
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q <= IDLE;
            rec_q   <= '0;
            sub_q   <= '0;
            obs_q   <= '0;
            rwd_q   <= '0;
            sta_q   <= '0;
            done_q  <= '0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            rec_q   <= rec_d;
            sub_q   <= sub_d;
            obs_q   <= obs_d;
            rwd_q   <= rwd_d;
            sta_q   <= sta_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule
